// File: rtl/sp_ram_sync_rw.sv
// Single-port RAM with synchronous write, synchronous read, and a shared tri-state data bus.
// The word is split into VEC_W-bit lanes; each lane keeps its own storage slice and read register.

module sp_ram_lane #(
  parameter int ADDR_WIDTH = 8,
  parameter int VEC_W      = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [VEC_W-1:0]      wdata,
  output logic [VEC_W-1:0]      rd_q
);

  logic [VEC_W-1:0] mem [RAM_DEPTH];

  // Storage has no reset; a write landing on a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_q <= '0;
    else if (rd_en) rd_q <= mem[addr];
  end

endmodule

module sp_ram_sync_rw #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int VEC_W      = 8,
  parameter int NUM_LANES  = DATA_WIDTH / VEC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  inout  wire  [DATA_WIDTH-1:0] data
);

  typedef struct packed {
    logic                  wr;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] addr;
  } ram_req_t;

  ram_req_t                           req;
  logic [NUM_LANES-1:0][VEC_W-1:0]    wdata_l;
  logic [NUM_LANES-1:0][VEC_W-1:0]    rdata_l;
  logic                               drive_en;

  // we wins over oe, so a write never loads rd_q or drives the bus.
  always_comb begin
    req      = '0;
    req.wr   = cs & we;
    req.rd   = cs & ~we & oe;
    req.addr = address;
  end

  assign wdata_l  = data;
  assign drive_en = req.rd;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sp_ram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .VEC_W      (VEC_W),
      .RAM_DEPTH  (RAM_DEPTH)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .wr_en (req.wr),
      .rd_en (req.rd),
      .addr  (req.addr),
      .wdata (wdata_l[l]),
      .rd_q  (rdata_l[l])
    );
  end

  assign data = drive_en ? rdata_l : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_ram_sync_rw.sv
// Directed bench for sp_ram_sync_rw: an array/register model checked every cycle plus literal spot checks.
// The bus has pull-ups, so an undriven bus reads as all ones.

module tb_sp_ram_sync_rw;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam logic [DW-1:0] BUS_Z = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic          cs, we, oe;
  logic          drv_en;
  logic [DW-1:0] drv_val;
  wire  [DW-1:0] data;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  assign data = drv_en ? drv_val : {DW{1'bz}};
  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (data[i]);
  end

  sp_ram_sync_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .cs      (cs),
    .we      (we),
    .oe      (oe),
    .data    (data)
  );

  always #5 clk = ~clk;

  // Model: memory as an associative array, plus the last word read.
  logic [DW-1:0] m_mem [int];
  logic [DW-1:0] m_rdq = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) m_rdq = '0;
    else if (cs && we) m_mem[int'(address)] = drv_val;
    else if (cs && oe) m_rdq = m_mem[int'(address)];
  end

  function automatic logic [DW-1:0] bus_expect();
    if (cs && !we && oe) return m_rdq;
    if (drv_en)          return drv_val;
    return BUS_Z;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: bus=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) chk("model_bus", data, bus_expect());
  end

  task automatic drive(input logic c, input logic w, input logic o, input logic [AW-1:0] a,
                       input logic de, input logic [DW-1:0] dv);
    @(negedge clk);
    #1;
    cs = c; we = w; oe = o; address = a; drv_en = de; drv_val = dv;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bus=%h expected=%h", data, '0);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; cs = 1'b0; we = 1'b0; oe = 1'b0; address = '0; drv_en = 1'b0; drv_val = '0;
    #1 rst = 1'b1;
    #1 cs = 1'b1; oe = 1'b1;
    #1 chk("rst_rdq_zero", data, 32'h0000_0000);
    cs = 1'b0;
    #1 chk("rst_cs0_z", data, BUS_Z);
    chk_on = 1'b1;
    @(negedge clk); #1 rst = 1'b0;

    // write then read 0x05; oe high during the write must be ignored
    drive(1, 1, 1, 8'h05, 1, 32'hDEAD_BEEF);
    after_edge(); chk("wr05_bus", data, 32'hDEAD_BEEF);
    drive(1, 0, 1, 8'h05, 0, '0);
    #1 chk("rd05_before_edge", data, 32'h0000_0000);
    after_edge(); chk("rd05", data, 32'hDEAD_BEEF);

    // rd_q holds 0xDEADBEEF here, so a RAM driving during a write would corrupt the bus
    drive(1, 1, 0, 8'h00, 1, 32'h1111_1111);
    after_edge(); chk("wr00_bus", data, 32'h1111_1111);
    drive(1, 1, 1, 8'hFF, 1, 32'hFFFF_FFFF);
    drive(1, 0, 1, 8'h00, 0, '0);
    after_edge(); chk("b2b_00", data, 32'h1111_1111);
    drive(1, 0, 1, 8'hFF, 0, '0);
    after_edge(); chk("b2b_ff", data, 32'hFFFF_FFFF);
    drive(1, 0, 1, 8'h00, 0, '0);
    after_edge(); chk("b2b_00_again", data, 32'h1111_1111);

    // drop/reassert oe and cs between edges
    drive(1, 0, 1, 8'h05, 0, '0);
    after_edge(); chk("rd05_again", data, 32'hDEAD_BEEF);
    oe = 1'b0; #1 chk("oe_drop_z", data, BUS_Z);
    oe = 1'b1; #1 chk("oe_back_hold", data, 32'hDEAD_BEEF);
    cs = 1'b0; #1 chk("cs_drop_z", data, BUS_Z);
    cs = 1'b1; #1 chk("cs_back_hold", data, 32'hDEAD_BEEF);

    // read with oe low must not load rd_q
    drive(1, 0, 0, 8'h00, 0, '0);
    after_edge(); chk("oe0_z", data, BUS_Z);
    oe = 1'b1; #1 chk("oe0_no_load", data, 32'hDEAD_BEEF);

    // write with cs low is ignored
    drive(0, 1, 1, 8'h05, 1, 32'h1234_5678);
    after_edge(); chk("cs0_wr_bus", data, 32'h1234_5678);
    drive(1, 0, 1, 8'hFF, 0, '0);
    drive(1, 0, 1, 8'h05, 0, '0);
    after_edge(); chk("cs0_wr_dropped", data, 32'hDEAD_BEEF);

    // async reset mid-read, then a write held across a reset edge
    #1 rst = 1'b1;
    #1 chk("rst_async_zero", data, 32'h0000_0000);
    drive(1, 1, 0, 8'h05, 1, 32'hCAFE_F00D);
    after_edge(); chk("rst_wr_bus", data, 32'hCAFE_F00D);
    drive(1, 0, 1, 8'h05, 0, '0);
    #1 chk("rst_hold_zero", data, 32'h0000_0000);
    rst = 1'b0;
    after_edge(); chk("mem_retained", data, 32'hDEAD_BEEF);
    drive(1, 0, 1, 8'h00, 0, '0);
    after_edge(); chk("mem_retained_00", data, 32'h1111_1111);

    drive(0, 0, 0, 8'h00, 0, '0);
    after_edge(); chk("idle_z", data, BUS_Z);
    @(negedge clk); #1;
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
